// File: rtl/hilo_mdu_if.sv
// HI/LO multiply-divide unit request/response bundle.
// The master issues operations; the slave (the MDU) reports start/busy and read data.
interface hilo_mdu_if;
  logic        md_valid;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic [31:0] hi_lo;

  modport master (
    output md_valid,
    output md_op,
    output rs_data,
    output rt_data,
    input  start,
    input  busy,
    input  hi_lo
  );

  modport slave (
    input  md_valid,
    input  md_op,
    input  rs_data,
    input  rt_data,
    output start,
    output busy,
    output hi_lo
  );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit.
// Accepts MULT/MULTU/DIV/DIVU, stays busy for a fixed number of cycles, then commits
// the result into HI/LO. MTHI/MTLO write directly when idle; MFHI/MFLO read combinationally.
module hilo_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  hilo_mdu_if.slave md
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic              is_md_op;
  logic              start;
  logic              busy;
  logic [31:0]       hi_lo;

  logic [63:0]       prod;
  logic              div_signed;
  logic              a_neg, b_neg;
  logic [31:0]       a_mag, b_mag, b_safe;
  logic [31:0]       q_mag, r_mag;
  logic [31:0]       res_hi, res_lo;
  logic              res_write;

  assign is_md_op = (md.md_op == OpMult) || (md.md_op == OpMultu) ||
                    (md.md_op == OpDiv)  || (md.md_op == OpDivu);

  // Result datapath: evaluated from the latched operands, consumed on the commit edge.
  always_comb begin
    prod       = '0;
    div_signed = (op_q == OpDiv);
    a_neg      = div_signed & a_q[31];
    b_neg      = div_signed & b_q[31];
    // Signed divide runs on magnitudes so the 0x80000000 / -1 case falls out naturally.
    a_mag      = a_neg ? (32'd0 - a_q) : a_q;
    b_mag      = b_neg ? (32'd0 - b_q) : b_q;
    b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    res_hi     = hi_q;
    res_lo     = lo_q;
    res_write  = 1'b0;
    case (op_q)
      OpMult: begin
        prod      = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        res_hi    = prod[63:32];
        res_lo    = prod[31:0];
        res_write = 1'b1;
      end
      OpMultu: begin
        prod      = {32'd0, a_q} * {32'd0, b_q};
        res_hi    = prod[63:32];
        res_lo    = prod[31:0];
        res_write = 1'b1;
      end
      OpDiv, OpDivu: begin
        res_lo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        res_hi    = a_neg ? (32'd0 - r_mag) : r_mag;
        // A zero divisor still takes the full busy period but leaves HI/LO alone.
        res_write = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  // State register: asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: accept, count down, commit, and idle-time HI/LO moves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          op_d    = md.md_op;
          a_d     = md.rs_data;
          b_d     = md.rt_data;
          cnt_d   = ((md.md_op == OpMult) || (md.md_op == OpMultu)) ?
                    CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        end else if (md.md_valid && (md.md_op == OpMthi)) begin
          hi_d = md.rs_data;
        end else if (md.md_valid && (md.md_op == OpMtlo)) begin
          lo_d = md.rs_data;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        // The edge closing the last busy cycle commits and returns to idle.
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (res_write) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: busy from state, start gated by busy, combinational MF read mux.
  always_comb begin
    busy  = (state_q == StRun);
    start = md.md_valid & is_md_op & ~busy;
    hi_lo = (md.md_op == OpMfhi) ? hi_q : lo_q;
  end

  assign md.busy  = busy;
  assign md.start = start;
  assign md.hi_lo = hi_lo;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed corner cases followed by random operations,
// compared against an arithmetic reference model of HI/LO.
module tb_hilo_mdu;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hilo_mdu_if md_if ();

  hilo_mdu #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md_if.slave)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m     = '0;
  logic [31:0] lo_m     = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: MIPS HI/LO semantics in plain 64-bit arithmetic.
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin q = sa * sb; {hi_m, lo_m} = q; end
      4'd2: begin pu = ua * ub; {hi_m, lo_m} = pu; end
      4'd3: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      4'd4: if (b != 32'd0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      4'd7: hi_m = a;
      4'd8: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    md_if.md_valid = 1'b0;
    md_if.md_op = 4'd5;
    #1 chk({tag, " hi"}, md_if.hi_lo, hi_m);
    md_if.md_op = 4'd6;
    #1 chk({tag, " lo"}, md_if.hi_lo, lo_m);
    md_if.md_op = 4'd0;
  endtask

  // Issue an md op from just after a rising edge and track its busy window.
  // With poke set, DIVU / MTLO 0xAAAA are presented throughout the busy window.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    int unsigned n;
    n = (op <= 4'd2) ? MultN : DivN;
    md_if.md_valid = 1'b1;
    md_if.md_op    = op;
    md_if.rs_data  = a;
    md_if.rt_data  = b;
    #1 chk({tag, " start"}, {31'd0, md_if.start}, 32'd1);
    @(posedge clk);
    #1;
    md_if.md_valid = 1'b0;
    md_if.md_op    = 4'd0;
    for (int i = 1; i <= int'(n); i++) begin
      if (poke) begin
        md_if.md_valid = 1'b1;
        md_if.md_op    = i[0] ? 4'd4 : 4'd8;
        md_if.rs_data  = 32'hAAAA;
        md_if.rt_data  = 32'd3;
        #1 chk({tag, " start while busy"}, {31'd0, md_if.start}, 32'd0);
      end
      chk({tag, " busy"}, {31'd0, md_if.busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    md_if.md_valid = 1'b0;
    md_if.md_op    = 4'd0;
    chk({tag, " busy end"}, {31'd0, md_if.busy}, 32'd0);
    apply(op, a, b);
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    md_if.md_valid = 1'b1;
    md_if.md_op    = op;
    md_if.rs_data  = a;
    @(posedge clk);
    #1;
    md_if.md_valid = 1'b0;
    md_if.md_op    = 4'd0;
    apply(op, a, 32'd0);
  endtask

  task automatic do_nop(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.md_valid = 1'b1;
    md_if.md_op    = op;
    md_if.rs_data  = a;
    md_if.rt_data  = b;
    #1 chk("nop start", {31'd0, md_if.start}, 32'd0);
    @(posedge clk);
    #1;
    md_if.md_valid = 1'b0;
    md_if.md_op    = 4'd0;
    chk("nop busy", {31'd0, md_if.busy}, 32'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int unsigned k;

    md_if.md_valid = 1'b0;
    md_if.md_op    = 4'd0;
    md_if.rs_data  = '0;
    md_if.rt_data  = '0;

    // Held in reset: outputs cleared, start still decodes, edges do nothing.
    #2;
    chk("rst busy", {31'd0, md_if.busy}, 32'd0);
    check_regs("rst");
    md_if.md_valid = 1'b1;
    md_if.md_op    = 4'd1;
    md_if.rs_data  = 32'd7;
    md_if.rt_data  = 32'd7;
    #1 chk("rst start", {31'd0, md_if.start}, 32'd1);
    @(posedge clk);
    #1 chk("rst edge busy", {31'd0, md_if.busy}, 32'd0);
    md_if.md_valid = 1'b0;
    md_if.md_op    = 4'd0;
    reset = 1'b1;
    check_regs("post rst");

    // Directed cases.
    run_md("mult -2*3", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    md_if.md_op = 4'd6;
    #1 chk("mult lo const", md_if.hi_lo, 32'hFFFF_FFFA);
    md_if.md_op = 4'd5;
    #1 chk("mult hi const", md_if.hi_lo, 32'hFFFF_FFFF);
    check_regs("mult");

    run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    md_if.md_op = 4'd5;
    #1 chk("multu hi const", md_if.hi_lo, 32'h0000_0001);
    md_if.md_op = 4'd6;
    #1 chk("multu lo const", md_if.hi_lo, 32'hFFFF_FFFE);

    run_md("div -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    md_if.md_op = 4'd6;
    #1 chk("div lo const", md_if.hi_lo, 32'hFFFF_FFFD);
    md_if.md_op = 4'd5;
    #1 chk("div hi const", md_if.hi_lo, 32'hFFFF_FFFF);

    do_mt(4'd7, 32'h1234);
    do_mt(4'd8, 32'h5678);
    run_md("divu by 0", 4'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
    md_if.md_op = 4'd5;
    #1 chk("div0 hi const", md_if.hi_lo, 32'h1234);
    md_if.md_op = 4'd6;
    #1 chk("div0 lo const", md_if.hi_lo, 32'h5678);

    run_md("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    md_if.md_op = 4'd6;
    #1 chk("ovf lo const", md_if.hi_lo, 32'h8000_0000);
    md_if.md_op = 4'd5;
    #1 chk("ovf hi const", md_if.hi_lo, 32'h0000_0000);

    run_md("mult poked", 4'd1, 32'd7, 32'd9, 1'b1);
    md_if.md_op = 4'd6;
    #1 chk("poked lo const", md_if.hi_lo, 32'd63);
    check_regs("poked");

    // Reset in the third busy cycle of a DIV.
    md_if.md_valid = 1'b1;
    md_if.md_op    = 4'd3;
    md_if.rs_data  = 32'd100;
    md_if.rt_data  = 32'd7;
    #1 chk("abort start", {31'd0, md_if.start}, 32'd1);
    @(posedge clk);
    #1;
    md_if.md_valid = 1'b0;
    md_if.md_op    = 4'd0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 chk("abort busy pre", {31'd0, md_if.busy}, 32'd1);
    reset = 1'b0;
    #1 chk("abort busy", {31'd0, md_if.busy}, 32'd0);
    hi_m = '0;
    lo_m = '0;
    check_regs("abort");
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_regs("abort release");
    run_md("mult after rst", 4'd1, 32'h0001_0000, 32'h0003_0000, 1'b0);
    check_regs("mult after rst");

    // Random operations, back to back, against the model.
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 9);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'(ra[15:0])};
      case (k)
        0, 1, 2, 3, 4, 5: begin
          rop = 4'(1 + (k % 4));
          run_md("rand md", rop, ra, rb, 1'b0);
        end
        6: do_mt(4'd7, ra);
        7: do_mt(4'd8, ra);
        8: do_nop(4'(9 + $urandom_range(0, 6)), ra, rb);
        default: do_nop(4'd0, ra, rb);
      endcase
      check_regs("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU, in cycles.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU, in cycles.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 md_valid  input  1  md_op is valid this cycle.
REQ-006 md_op  input  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 are treated as NOP.
REQ-007 rs_data  input  32  operand A (dividend / multiplicand / MT source).
REQ-008 rt_data  input  32  operand B (divisor / multiplier).
REQ-009 start  output  1  current md_op is accepted as a multiply/divide this cycle.
REQ-010 busy  output  1  an accepted multiply/divide is in progress.
REQ-011 hi_lo  output  32  read data for MFHI/MFLO.

Function
REQ-012 Opcodes 1-4 are "md ops"; start SHALL equal md_valid & (md_op is an md op) & ~busy, combinationally.
REQ-013 On a rising edge with start=1: latch rs_data, rt_data and the op, load the cycle counter with MULT_CYCLES or DIV_CYCLES, and go from IDLE to RUN.
REQ-014 busy SHALL be high for exactly N consecutive cycles, starting the cycle after start (N = MULT_CYCLES or DIV_CYCLES).
REQ-015 On the edge that ends the last busy cycle: commit HI/LO, return to IDLE, deassert busy.
REQ-016 The committed HI/LO SHALL be visible on hi_lo in the first cycle with busy=0.
REQ-017 MULT: {HI,LO} = signed 64-bit product. MULTU: {HI,LO} = unsigned 64-bit product.
REQ-018 DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-019 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-020 Divisor 0: the operation runs its full DIV_CYCLES busy period, but HI and LO SHALL be left unchanged.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-022 MTHI/MTLO with md_valid=1 and busy=0: write rs_data to HI/LO on the edge.
REQ-023 MTHI/MTLO while busy=1: ignored, with no register change.
REQ-024 Any md op presented while busy=1: ignored; start=0; in-flight operation unaffected (upstream holds and retries).
REQ-025 hi_lo SHALL be combinational: HI when md_op=5, else LO. It returns the current register value regardless of busy; stalling MF while busy|start is upstream's job.
REQ-026 md_valid=0 or NOP: no state change.
REQ-027 Result computation (combinational at commit or iterative) is an implementation choice; only the cycle timing in REQ-014/015 is observable.
REQ-028 A new md op MAY be accepted in the first cycle with busy=0 (back-to-back: one idle cycle between busy windows).

Reset
REQ-029 While reset=0: HI=0, LO=0, counter=0, state=IDLE, busy=0, latched operands=0, taking effect immediately and asynchronously.
REQ-030 start follows REQ-012 during reset (busy=0); edges during reset SHALL NOT change state.
REQ-031 Reset asserted mid-operation aborts the operation with no HI/LO commit.
REQ-032 After reset deassertion the block is in IDLE with hi_lo=0.

Verification
REQ-033 MULT rs=0xFFFFFFFE (-2), rt=3 -> start=1 in cycle T; busy=1 in T+1..T+5; MFLO in T+6 reads 0xFFFFFFFA; MFHI reads 0xFFFFFFFF.
REQ-034 MULTU rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 MTHI 0x1234, MTLO 0x5678, then DIVU rt=0 -> busy for 10 cycles; afterwards HI=0x1234, LO=0x5678.
REQ-037 During a MULT busy window, present DIVU and MTLO 0xAAAA -> start=0; LO ends equal to the MULT result, not 0xAAAA.
REQ-038 Pull reset low in the 3rd busy cycle of a DIV -> busy=0 immediately; HI=LO=0; a MULT issued after release completes in 5 cycles.
